// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if -- request / control bundle between the pipeline and pipe_ctrl.
//
// Request inputs (to the controller):
//   stall_reg1, stall_reg2 : load-use stall requests from the hazard unit
//   br_taken               : branch/jump resolved taken in EX
//   imem_stall             : instruction memory not ready
//   dmem_stall             : data memory not ready
//   halt_wb                : HALT instruction committing in WB
// Control outputs (from the controller):
//   pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
//   ex_mem_en, ex_mem_bubble, mem_wb_en, halted, mem_err
//   perf_stall[15:0], perf_flush[15:0]   (only with PIPE_CTRL_PERF_EN)
//
// modport master : the controller side (drives the control outputs)
// modport slave  : the pipeline side (drives the requests)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic        stall_reg1;
    logic        stall_reg2;
    logic        br_taken;
    logic        imem_stall;
    logic        dmem_stall;
    logic        halt_wb;
    logic        pc_en;
    logic        pc_sel_br;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_bubble;
    logic        ex_mem_en;
    logic        ex_mem_bubble;
    logic        mem_wb_en;
    logic        halted;
    logic        mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_stall;
    logic [15:0] perf_flush;

    modport master (
        input  stall_reg1, stall_reg2, br_taken, imem_stall, dmem_stall, halt_wb,
        output pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, ex_mem_bubble, mem_wb_en, halted, mem_err,
               perf_stall, perf_flush
    );

    modport slave (
        output stall_reg1, stall_reg2, br_taken, imem_stall, dmem_stall, halt_wb,
        input  pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, ex_mem_bubble, mem_wb_en, halted, mem_err,
               perf_stall, perf_flush
    );
`else
    modport master (
        input  stall_reg1, stall_reg2, br_taken, imem_stall, dmem_stall, halt_wb,
        output pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, ex_mem_bubble, mem_wb_en, halted, mem_err
    );

    modport slave (
        output stall_reg1, stall_reg2, br_taken, imem_stall, dmem_stall, halt_wb,
        input  pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, ex_mem_bubble, mem_wb_en, halted, mem_err
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline stall / flush / halt controller.
//
// Ports:
//   clk  : pipeline clock
//   rst  : synchronous active-high reset
//   bus  : pipe_ctrl_if.master (requests in, stage enables / flushes out)
//
// Stage controls are combinational from the current state and the requests.
// Priority each cycle: rst > halted > halt_wb > dmem_stall > br_taken >
// imem_stall > load-use.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the 16-bit saturating
// perf_stall / perf_flush counters.
// -----------------------------------------------------------------------------
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDUSE   = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    // Control vector layout, MSB first:
    // {pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
    //  ex_mem_en, ex_mem_bubble, mem_wb_en}
    localparam logic [8:0] CTRL_IDLE   = 9'b1_0_1_0_1_0_1_0_1;
    localparam logic [8:0] CTRL_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] CTRL_RESET  = 9'b0_0_0_1_0_1_0_1_0;
    localparam logic [8:0] CTRL_BRANCH = 9'b1_1_1_1_1_1_1_0_1;
    localparam logic [8:0] CTRL_IMEM   = 9'b0_0_1_1_1_0_1_0_1;
    localparam logic [8:0] CTRL_LDUSE  = 9'b0_0_0_0_0_0_1_1_1;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [8:0] ctrl_s;
    logic       halted_s;
    logic       load_use_s;
    logic [7:0] wait_cnt_r;
    logic       mem_err_r;

    // The stall request seen during LDUSE refers to the instruction already
    // bubbled, so it is ignored there.
    assign load_use_s = (bus.stall_reg1 | bus.stall_reg2) & (state_r != ST_LDUSE);

    // Stage controls and next state, evaluated in request-priority order.
    // MEMWAIT with dmem_stall low behaves like RUN so that requests held in
    // the frozen stages are serviced in that same cycle.
    always_comb begin
        ctrl_s       = CTRL_IDLE;
        halted_s     = 1'b0;
        state_next_s = ST_RUN;
        if (rst) begin
            ctrl_s       = CTRL_RESET;
            state_next_s = ST_RUN;
        end else if (state_r == ST_HALT) begin
            ctrl_s       = CTRL_FREEZE;
            halted_s     = 1'b1;
            state_next_s = ST_HALT;
        end else if (bus.halt_wb) begin
            ctrl_s       = CTRL_FREEZE;
            state_next_s = ST_HALT;
        end else if (bus.dmem_stall) begin
            ctrl_s       = CTRL_FREEZE;
            state_next_s = ST_MEMWAIT;
        end else if (bus.br_taken) begin
            ctrl_s       = CTRL_BRANCH;
            state_next_s = ST_RUN;
        end else if (bus.imem_stall) begin
            ctrl_s       = CTRL_IMEM;
            state_next_s = ST_RUN;
        end else if (load_use_s) begin
            ctrl_s       = CTRL_LDUSE;
            state_next_s = ST_LDUSE;
        end else begin
            ctrl_s       = CTRL_IDLE;
            state_next_s = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // MEMWAIT cycle counter (zero on entry, saturating) and sticky mem_err.
    // mem_err is raised on the same edge the counter reaches 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
            mem_err_r  <= 1'b0;
        end else if ((state_r == ST_MEMWAIT) && (state_next_s == ST_MEMWAIT)) begin
            if (wait_cnt_r != 8'hFF) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (wait_cnt_r == 8'hFE) begin
                mem_err_r <= 1'b1;
            end else begin
                mem_err_r <= mem_err_r;
            end
        end else begin
            wait_cnt_r <= 8'd0;
            mem_err_r  <= mem_err_r;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_stall_r;
    logic [15:0] perf_flush_r;

    // Saturating stall / branch-flush cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= 16'd0;
            perf_flush_r <= 16'd0;
        end else begin
            if (!ctrl_s[8] && (state_r != ST_HALT) && (perf_stall_r != 16'hFFFF)) begin
                perf_stall_r <= perf_stall_r + 16'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (ctrl_s[7] && (perf_flush_r != 16'hFFFF)) begin
                perf_flush_r <= perf_flush_r + 16'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign bus.perf_stall = perf_stall_r;
    assign bus.perf_flush = perf_flush_r;
`endif

    assign bus.pc_en         = ctrl_s[8];
    assign bus.pc_sel_br     = ctrl_s[7];
    assign bus.if_id_en      = ctrl_s[6];
    assign bus.if_id_flush   = ctrl_s[5];
    assign bus.id_ex_en      = ctrl_s[4];
    assign bus.id_ex_bubble  = ctrl_s[3];
    assign bus.ex_mem_en     = ctrl_s[2];
    assign bus.ex_mem_bubble = ctrl_s[1];
    assign bus.mem_wb_en     = ctrl_s[0];
    assign bus.halted        = halted_s;
    assign bus.mem_err       = mem_err_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl: a table of single-cycle
// vectors, hand-written multi-cycle sequences, and randomized traffic checked
// against a behavioural model built from the controller's rules.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected control patterns, MSB first:
    // {pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
    //  ex_mem_en, ex_mem_bubble, mem_wb_en}
    localparam logic [8:0] P_IDLE   = 9'b101010101;
    localparam logic [8:0] P_FREEZE = 9'b000000000;
    localparam logic [8:0] P_RESET  = 9'b000101010;
    localparam logic [8:0] P_BRANCH = 9'b111111101;
    localparam logic [8:0] P_IMEM   = 9'b001110101;
    localparam logic [8:0] P_LDUSE  = 9'b000000111;

    typedef struct packed {
        logic       s1;
        logic       s2;
        logic       br;
        logic       im;
        logic       dm;
        logic [8:0] exp;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;

    // behavioural model state
    bit mHalted;
    bit mStale;
    bit mErr;
    int mRun;
    int mPerfStall;
    int mPerfFlush;

    logic [8:0] lastVec;
    logic       lastHalted;
    logic       lastErr;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctrlVec();
        return {bus.pc_en, bus.pc_sel_br, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                bus.id_ex_bubble, bus.ex_mem_en, bus.ex_mem_bubble, bus.mem_wb_en};
    endfunction

    // Expected stage controls from the priority rules.
    function automatic logic [8:0] expOut(input bit r, input bit hlt, input bit s1, input bit s2,
                                          input bit br, input bit im, input bit dm,
                                          input bit hw, input bit stale);
        if (r)                     return P_RESET;
        if (hlt || hw || dm)       return P_FREEZE;
        if (br)                    return P_BRANCH;
        if (im)                    return P_IMEM;
        if ((s1 || s2) && !stale)  return P_LDUSE;
        return P_IDLE;
    endfunction

    // One clock cycle: drive, compare against model at negedge, advance model.
    task automatic step(input bit r, input bit s1, input bit s2, input bit br,
                        input bit im, input bit dm, input bit hw);
        logic [8:0] e;
        rst            = r;
        bus.stall_reg1 = s1;
        bus.stall_reg2 = s2;
        bus.br_taken   = br;
        bus.imem_stall = im;
        bus.dmem_stall = dm;
        bus.halt_wb    = hw;
        @(negedge clk);
        e          = expOut(r, mHalted, s1, s2, br, im, dm, hw, mStale);
        lastVec    = ctrlVec();
        lastHalted = bus.halted;
        lastErr    = bus.mem_err;
        check("ctrl", 16'(lastVec), 16'(e));
        check("halted", 16'(lastHalted), 16'(mHalted && !r));
        if (!r) begin
            check("mem_err", 16'(lastErr), 16'(mErr));
`ifdef PIPE_CTRL_PERF_EN
            check("perf_stall", bus.perf_stall, 16'(mPerfStall));
            check("perf_flush", bus.perf_flush, 16'(mPerfFlush));
`endif
        end
        @(posedge clk);
        if (r) begin
            mHalted    = 1'b0;
            mStale     = 1'b0;
            mErr       = 1'b0;
            mRun       = 0;
            mPerfStall = 0;
            mPerfFlush = 0;
        end else begin
            if (!mHalted && !e[8] && mPerfStall < 65535) mPerfStall++;
            if (e[7] && mPerfFlush < 65535) mPerfFlush++;
            if (!mHalted) begin
                if (hw) begin
                    mHalted = 1'b1;
                    mStale  = 1'b0;
                    mRun    = 0;
                end else begin
                    mRun = dm ? mRun + 1 : 0;
                    if (mRun >= 256) mErr = 1'b1;
                    mStale = !dm && !br && !im && (s1 || s2) && !mStale;
                end
            end
        end
        #1;
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{s1: 1'b0, s2: 1'b0, br: 1'b0, im: 1'b0, dm: 1'b0, exp: P_IDLE};
        tbl[1] = '{s1: 1'b1, s2: 1'b0, br: 1'b0, im: 1'b0, dm: 1'b0, exp: P_LDUSE};
        tbl[2] = '{s1: 1'b0, s2: 1'b1, br: 1'b0, im: 1'b0, dm: 1'b0, exp: P_LDUSE};
        tbl[3] = '{s1: 1'b0, s2: 1'b0, br: 1'b1, im: 1'b0, dm: 1'b0, exp: P_BRANCH};
        tbl[4] = '{s1: 1'b0, s2: 1'b0, br: 1'b0, im: 1'b1, dm: 1'b0, exp: P_IMEM};
        tbl[5] = '{s1: 1'b0, s2: 1'b0, br: 1'b0, im: 1'b0, dm: 1'b1, exp: P_FREEZE};
        tbl[6] = '{s1: 1'b1, s2: 1'b0, br: 1'b1, im: 1'b1, dm: 1'b0, exp: P_BRANCH};
        tbl[7] = '{s1: 1'b0, s2: 1'b1, br: 1'b0, im: 1'b1, dm: 1'b0, exp: P_IMEM};
        tbl[8] = '{s1: 1'b0, s2: 1'b0, br: 1'b1, im: 1'b1, dm: 1'b1, exp: P_FREEZE};
        tbl[9] = '{s1: 1'b1, s2: 1'b1, br: 1'b0, im: 1'b0, dm: 1'b1, exp: P_FREEZE};

        // reset for two cycles, then idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_pc_en", 16'(lastVec[8]), 16'd0);
        check("rst_flush_bubble", 16'({lastVec[5], lastVec[3]}), 16'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_pattern", 16'(lastVec), 16'(P_RESET));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_idle", 16'(lastVec), 16'(P_IDLE));
        check("post_rst_err", 16'(lastErr), 16'd0);

        // single-cycle vectors from RUN
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, tbl[i].s1, tbl[i].s2, tbl[i].br, tbl[i].im, tbl[i].dm, 1'b0);
            check($sformatf("tbl%0d", i), 16'(lastVec), 16'(tbl[i].exp));
        end

        // stall_reg2 held two cycles: exactly one bubble
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_c1_pc_en", 16'(lastVec[8]), 16'd0);
        check("lu_c1_bubble", 16'(lastVec[1]), 16'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_c2_pc_en", 16'(lastVec[8]), 16'd1);
        check("lu_c2_bubble", 16'(lastVec[1]), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_after", 16'(lastVec), 16'(P_IDLE));

        // dmem_stall for 3 cycles with br_taken held, then the flush
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("dm_br_freeze%0d", i), 16'(lastVec), 16'(P_FREEZE));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dm_br_flush", 16'(lastVec), 16'(P_BRANCH));
`ifdef PIPE_CTRL_PERF_EN
        check("perf_flush_one", bus.perf_flush, 16'd1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dm_br_after", 16'(lastVec), 16'(P_IDLE));

        // long dmem_stall: mem_err once the counter reaches 255
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 255) check("mem_err_before", 16'(lastErr), 16'd0);
            if (i == 256) check("mem_err_rise", 16'(lastErr), 16'd1);
        end
        check("mem_err_freeze", 16'(lastVec), 16'(P_FREEZE));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mem_err_sticky", 16'(lastErr), 16'd1);
        check("mem_err_resume", 16'(lastVec), 16'(P_IDLE));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mem_err_cleared", 16'(lastErr), 16'd0);

        // rst in the middle of MEMWAIT leaves no freeze behind
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("memwait_abort", 16'(lastVec), 16'(P_IDLE));

        // halt_wb with dmem_stall: sticky HALT until rst
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check($sformatf("halt_sticky%0d", i), 16'({lastHalted, lastVec}), 16'h200);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_rst_halted", 16'(lastHalted), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_rst_run", 16'({lastHalted, lastVec}), 16'(P_IDLE));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 499) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
